layer_engine_pooler: RTL and testbench

Streaming 3x3, stride-1 max-pooling engine for the CNN layer accelerator's layer engine. It receives a frame geometry through a 64-bit opcode, then accepts a raster-order stream of unsigned pixels. It emits one maximum per fully covered 3x3 window, so an H×W frame produces (H-2)×(W-2) outputs in raster order. It sits between the layer engine's data path and its output stage, with valid/ready handshakes on both sides.

---
 rtl/pooler_pkg.sv | 18 +
 rtl/pooler_line_buffer.sv | 51 +++++
 rtl/layer_engine_pooler.sv | 237 +++++++++++++++++++++++
 tb/tb_layer_engine_pooler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pooler_pkg.sv
// Shared definitions for the streaming 3x3 max-pooling engine:
// FSM states, opcode field layout and window geometry.
package pooler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pooler_state_e;

  localparam int unsigned OPC_W_LSB      = 0;
  localparam int unsigned OPC_H_LSB      = 16;
  localparam int unsigned OPC_FIELD_W    = 16;
  localparam int unsigned OPC_RSVD_LSB   = 32;
  localparam int unsigned WIN_SIZE       = 3;
  localparam int unsigned OUT_FIFO_DEPTH = 4;

endpackage

// File: rtl/pooler_line_buffer.sv
// Row delay line: each shift returns the sample written len_i shifts earlier.
// Circular buffer with a runtime wrap point; storage is deliberately not reset.
module pooler_line_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [15:0]       len_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     ptr_q, ptr_d;

  assign data_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (shift_i) begin
      if (32'(ptr_q) + 32'd1 >= 32'(len_i)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Read-before-write at the same slot yields exactly len_i samples of delay.
  always_ff @(posedge clk) begin
    if (shift_i && !clear_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/layer_engine_pooler.sv
// Streaming 3x3 stride-1 max-pooling engine with valid/ready on both sides.
// Define POOLER_OUT_FIFO_EN to replace the single output register with a 4-entry FIFO.
module layer_engine_pooler
  import pooler_pkg::*;
#(
  parameter int unsigned C_DATAIN_WIDTH  = 16,
  parameter int unsigned C_MAX_ROW_WIDTH = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               opcode,
  input  logic                      opcode_valid,
  output logic                      opcode_accept,
  input  logic [C_DATAIN_WIDTH-1:0] datain,
  input  logic                      datain_valid,
  output logic                      datain_ready,
  output logic [C_DATAIN_WIDTH-1:0] dataout,
  output logic                      dataout_valid,
  input  logic                      dataout_ready
);

  localparam int unsigned DW = C_DATAIN_WIDTH;

  pooler_state_e state_q, state_d;
  logic [15:0]   w_q, w_d, h_q, h_d;
  logic [15:0]   col_q, col_d, row_q, row_d;
  logic          geom_ok_q, geom_ok_d;
  logic          lb_clear;
  logic          in_xfer;
  logic          res_valid;
  logic [DW-1:0] res_max;
  logic          slot_space;
  logic          slot_empty_next;

  logic [15:0]   opc_w, opc_h;
  logic          unused_opcode_rsvd;

  logic [DW-1:0] lb0_out, lb1_out;
  logic [DW-1:0] new_col [WIN_SIZE];
  logic [DW-1:0] win_q   [WIN_SIZE][WIN_SIZE];

  assign opc_w              = opcode[OPC_W_LSB +: OPC_FIELD_W];
  assign opc_h              = opcode[OPC_H_LSB +: OPC_FIELD_W];
  assign unused_opcode_rsvd = ^opcode[63:OPC_RSVD_LSB];

  assign datain_ready = (state_q == ST_RUN) && slot_space;
  assign in_xfer      = datain_valid && datain_ready;

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    h_d           = h_q;
    col_d         = col_q;
    row_d         = row_q;
    geom_ok_d     = geom_ok_q;
    lb_clear      = 1'b0;
    opcode_accept = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (opcode_valid) begin
          opcode_accept = 1'b1;
          lb_clear      = 1'b1;
          w_d           = opc_w;
          h_d           = opc_h;
          col_d         = '0;
          row_d         = '0;
          geom_ok_d     = (opc_w >= 16'd3) && (opc_h >= 16'd3) &&
                          (32'(opc_w) <= C_MAX_ROW_WIDTH);
          state_d       = ((opc_w == 16'd0) || (opc_h == 16'd0)) ? ST_IDLE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_xfer) begin
          if (col_q == w_q - 16'd1) begin
            col_d = '0;
            row_d = row_q + 16'd1;
            if (row_q == h_q - 16'd1) begin
              state_d = ST_DRAIN;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_empty_next) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      geom_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      row_q     <= row_d;
      geom_ok_q <= geom_ok_d;
    end
  end

  // lb0 yields the pixel one row above; lb1 chains off it for two rows above.
  pooler_line_buffer #(
    .DATA_W (DW),
    .DEPTH  (C_MAX_ROW_WIDTH)
  ) u_lb0 (
    .clk     (clk),
    .rst     (rst),
    .clear_i (lb_clear),
    .shift_i (in_xfer),
    .len_i   (w_q),
    .data_i  (datain),
    .data_o  (lb0_out)
  );

  pooler_line_buffer #(
    .DATA_W (DW),
    .DEPTH  (C_MAX_ROW_WIDTH)
  ) u_lb1 (
    .clk     (clk),
    .rst     (rst),
    .clear_i (lb_clear),
    .shift_i (in_xfer),
    .len_i   (w_q),
    .data_i  (lb0_out),
    .data_o  (lb1_out)
  );

  always_comb begin
    new_col[0] = lb1_out;
    new_col[1] = lb0_out;
    new_col[2] = datain;
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      for (int unsigned k = 0; k < WIN_SIZE; k++) begin
        for (int unsigned j = 0; j + 1 < WIN_SIZE; j++) begin
          win_q[k][j] <= win_q[k][j+1];
        end
        win_q[k][WIN_SIZE-1] <= new_col[k];
      end
    end
  end

  // Max over the two newest stored columns plus the incoming column.
  always_comb begin
    res_max = '0;
    for (int unsigned k = 0; k < WIN_SIZE; k++) begin
      for (int unsigned j = 1; j < WIN_SIZE; j++) begin
        if (win_q[k][j] > res_max) begin
          res_max = win_q[k][j];
        end
      end
      if (new_col[k] > res_max) begin
        res_max = new_col[k];
      end
    end
  end

  assign res_valid = in_xfer && geom_ok_q && (row_q >= 16'd2) && (col_q >= 16'd2);

`ifdef POOLER_OUT_FIFO_EN
  logic [DW-1:0] fifo_q [OUT_FIFO_DEPTH];
  logic [1:0]    wr_q, rd_q;
  logic [2:0]    cnt_q, cnt_d;
  logic          pop;

  assign pop             = (cnt_q != 3'd0) && dataout_ready;
  assign cnt_d           = cnt_q + {2'b00, res_valid} - {2'b00, pop};
  assign slot_space      = (cnt_q != 3'(OUT_FIFO_DEPTH));
  assign slot_empty_next = (cnt_d == 3'd0);
  assign dataout         = fifo_q[rd_q];
  assign dataout_valid   = (cnt_q != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (res_valid) begin
        fifo_q[wr_q] <= res_max;
        wr_q         <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end
`else
  logic [DW-1:0] dout_q, dout_d;
  logic          dvalid_q, dvalid_d;

  // A taken result and a new one in the same cycle reload the slot without a bubble.
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    if (res_valid) begin
      dout_d   = res_max;
      dvalid_d = 1'b1;
    end else if (dataout_ready) begin
      dvalid_d = 1'b0;
    end
  end

  assign slot_space      = !dvalid_q || dataout_ready;
  assign slot_empty_next = !dvalid_d;
  assign dataout         = dout_q;
  assign dataout_valid   = dvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end
`endif

endmodule

// File: tb/tb_layer_engine_pooler.sv
// Self-checking bench for layer_engine_pooler: random and directed frames
// compared against a plain 3x3 sliding-max model over the stored frame.
module tb_layer_engine_pooler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] opcode = '0;
  logic        opcode_valid = 1'b0;
  logic        opcode_accept;
  logic [15:0] datain = '0;
  logic        datain_valid = 1'b0;
  logic        datain_ready;
  logic [15:0] dataout;
  logic        dataout_valid;
  logic        dataout_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [15:0] frame_px [100];
  logic [15:0] got_q [$];
  int          n_in;
  int          fh, fw;
  int          n_stall;
  bit          saw_valid;

  always #5 clk = ~clk;

  layer_engine_pooler #(
    .C_DATAIN_WIDTH  (16),
    .C_MAX_ROW_WIDTH (512)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .opcode_valid  (opcode_valid),
    .opcode_accept (opcode_accept),
    .datain        (datain),
    .datain_valid  (datain_valid),
    .datain_ready  (datain_ready),
    .dataout       (dataout),
    .dataout_valid (dataout_valid),
    .dataout_ready (dataout_ready)
  );

  function automatic int exp_count(input int h, input int w);
    if (h >= 3 && w >= 3 && w <= 512) return (h - 2) * (w - 2);
    return 0;
  endfunction

  function automatic logic [15:0] ref_max(input int i, input int j);
    logic [15:0] m = '0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        if (frame_px[(i + a) * fw + (j + b)] > m) m = frame_px[(i + a) * fw + (j + b)];
    return m;
  endfunction

  task automatic send_opcode(input int h, input int w, output bit ok);
    int cyc = 0;
    fh = h; fw = w; n_in = 0; n_stall = 0; saw_valid = 0;
    got_q.delete();
    @(negedge clk);
    opcode = {32'hDEAD_BEEF, 16'(h), 16'(w)};
    opcode_valid = 1'b1;
    #1;
    while (opcode_accept !== 1'b1 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    ok = (opcode_accept === 1'b1);
    @(posedge clk);
    #1 opcode_valid = 1'b0;
  endtask

  task automatic stream(input bit gaps, input bit rnd_rdy, input int max_cycles, output bit to);
    int cyc = 0;
    int npx = fh * fw;
    int ne  = exp_count(fh, fw);
    to = 0;
    while (n_in < npx || got_q.size() < ne) begin
      if (cyc >= max_cycles) begin to = 1; break; end
      @(negedge clk);
      datain_valid  = (n_in < npx) && (!gaps || $urandom_range(0, 3) != 0);
      datain        = (n_in < npx) ? frame_px[n_in] : 16'd0;
      dataout_ready = !rnd_rdy || ($urandom_range(0, 2) != 0);
      #1;
      if (dataout_valid) saw_valid = 1;
      if (datain_valid && !datain_ready) n_stall++;
      if (datain_valid && datain_ready) n_in++;
      if (dataout_valid && dataout_ready) got_q.push_back(dataout);
      cyc++;
    end
    @(negedge clk);
    datain_valid  = 1'b0;
    dataout_ready = 1'b1;
  endtask

  task automatic probe_idle(output logic acc, output logic rdy, output logic vld);
    @(negedge clk);
    dataout_ready = 1'b1;
    opcode = '0;
    opcode_valid = 1'b1;
    #1;
    acc = opcode_accept; rdy = datain_ready; vld = dataout_valid;
    opcode_valid = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) frame_px[r * 10 + c] = 16'(10 * r + c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (opcode_accept !== 1'b0) begin bad++; $display("FAIL rst_accept: got %b expected 0", opcode_accept); end
    total++; if (datain_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", datain_ready); end
    total++; if (dataout !== 16'd0) begin bad++; $display("FAIL rst_dataout: got %0d expected 0", dataout); end
    total++; if (dataout_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", dataout_valid); end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    bit ok, to;
    logic acc, rdy, vld;
    fill_ramp();
    send_opcode(10, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL ramp_accept: got 0 expected 1"); end
    stream(0, 0, 400, to);
    total++; if (to) begin bad++; $display("FAIL ramp_timeout: got %0d outputs expected 64", got_q.size()); end
    total++; if (got_q.size() != 64) begin bad++; $display("FAIL ramp_count: got %0d expected 64", got_q.size()); end
    total++; if (n_stall != 0) begin bad++; $display("FAIL ramp_throughput: got %0d stalls expected 0", n_stall); end
    for (int k = 0; k < got_q.size() && k < 64; k++) begin
      total++;
      if (got_q[k] !== 16'(22 + 10 * (k / 8) + (k % 8))) begin
        bad++; $display("FAIL ramp_val[%0d]: got %0d expected %0d", k, got_q[k], 22 + 10 * (k / 8) + (k % 8));
      end
    end
    probe_idle(acc, rdy, vld);
    total++; if (acc !== 1'b1 || rdy !== 1'b0 || vld !== 1'b0)
      begin bad++; $display("FAIL ramp_idle: got acc=%b rdy=%b vld=%b expected 1 0 0", acc, rdy, vld); end
  endtask

  task automatic test_random(input bit gaps, input bit rnd_rdy);
    bit ok, to;
    for (int p = 0; p < 100; p++) frame_px[p] = 16'($urandom_range(0, 100));
    send_opcode(10, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_accept: got 0 expected 1"); end
    stream(gaps, rnd_rdy, 2000, to);
    total++; if (got_q.size() != 64 || to)
      begin bad++; $display("FAIL rand_count: got %0d expected 64 (timeout=%0d)", got_q.size(), to); end
    for (int k = 0; k < got_q.size() && k < 64; k++) begin
      total++;
      if (got_q[k] !== ref_max(k / 8, k % 8)) begin
        bad++; $display("FAIL rand_val[%0d]: got %0d expected %0d", k, got_q[k], ref_max(k / 8, k % 8));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, to;
    bit held_ok = 1;
    fill_ramp();
    send_opcode(10, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_accept: got 0 expected 1"); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      datain_valid  = 1'b1;
      datain        = frame_px[n_in];
      dataout_ready = 1'b0;
      #1;
      if (dataout_valid && dataout !== 16'd22) held_ok = 0;
      if (datain_valid && datain_ready) n_in++;
    end
    total++; if (n_in != 23) begin bad++; $display("FAIL bp_accepted: got %0d expected 23", n_in); end
    total++; if (dataout !== 16'd22) begin bad++; $display("FAIL bp_dataout: got %0d expected 22", dataout); end
    total++; if (dataout_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b expected 1", dataout_valid); end
    total++; if (datain_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b expected 0", datain_ready); end
    total++; if (!held_ok) begin bad++; $display("FAIL bp_hold: got unstable output expected 22 held"); end
    stream(0, 0, 400, to);
    total++; if (got_q.size() != 64 || to)
      begin bad++; $display("FAIL bp_count: got %0d expected 64 (timeout=%0d)", got_q.size(), to); end
    for (int k = 0; k < got_q.size() && k < 64; k++) begin
      total++;
      if (got_q[k] !== 16'(22 + 10 * (k / 8) + (k % 8))) begin
        bad++; $display("FAIL bp_val[%0d]: got %0d expected %0d", k, got_q[k], 22 + 10 * (k / 8) + (k % 8));
      end
    end
  endtask

  task automatic test_single_peak();
    bit ok, to;
    int n100 = 0;
    for (int p = 0; p < 100; p++) frame_px[p] = 16'd0;
    frame_px[55] = 16'd100;
    send_opcode(10, 10, ok);
    stream(0, 0, 400, to);
    total++; if (got_q.size() != 64 || to || !ok)
      begin bad++; $display("FAIL peak_count: got %0d expected 64", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 64; k++) begin
      if (got_q[k] == 16'd100) n100++;
      total++;
      if (got_q[k] !== ref_max(k / 8, k % 8)) begin
        bad++; $display("FAIL peak_val[%0d]: got %0d expected %0d", k, got_q[k], ref_max(k / 8, k % 8));
      end
    end
    total++; if (n100 != 9) begin bad++; $display("FAIL peak_hits: got %0d expected 9", n100); end
  endtask

  task automatic test_degenerate();
    bit ok, to;
    logic acc, rdy, vld;
    for (int p = 0; p < 100; p++) frame_px[p] = 16'($urandom_range(1, 500));
    send_opcode(2, 5, ok);
    total++; if (!ok) begin bad++; $display("FAIL degen_accept: got 0 expected 1"); end
    stream(0, 0, 100, to);
    total++; if (n_in != 10 || to) begin bad++; $display("FAIL degen_consumed: got %0d expected 10", n_in); end
    probe_idle(acc, rdy, vld);
    total++; if (saw_valid || vld !== 1'b0)
      begin bad++; $display("FAIL degen_no_output: got valid seen=%0d expected 0", saw_valid); end
    total++; if (acc !== 1'b1 || rdy !== 1'b0)
      begin bad++; $display("FAIL degen_idle: got acc=%b rdy=%b expected 1 0", acc, rdy); end
    send_opcode(0, 5, ok);
    probe_idle(acc, rdy, vld);
    total++; if (!ok || acc !== 1'b1 || rdy !== 1'b0)
      begin bad++; $display("FAIL zero_geom: got ok=%0d acc=%b rdy=%b expected 1 1 0", ok, acc, rdy); end
  endtask

  task automatic test_reset_midframe();
    bit ok, to;
    logic acc, rdy, vld;
    int cyc = 0;
    fill_ramp();
    send_opcode(10, 10, ok);
    while (n_in < 40 && cyc < 100) begin
      @(negedge clk);
      datain_valid = 1'b1; datain = frame_px[n_in]; dataout_ready = 1'b1;
      #1;
      if (datain_ready) n_in++;
      cyc++;
    end
    @(negedge clk);
    datain_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (dataout_valid !== 1'b0 || datain_ready !== 1'b0)
      begin bad++; $display("FAIL midrst_outputs: got vld=%b rdy=%b expected 0 0", dataout_valid, datain_ready); end
    probe_idle(acc, rdy, vld);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL midrst_idle: got acc=%b expected 1", acc); end
    send_opcode(10, 10, ok);
    stream(0, 0, 400, to);
    total++; if (got_q.size() != 64 || to || !ok)
      begin bad++; $display("FAIL midrst_count: got %0d expected 64", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 64; k++) begin
      total++;
      if (got_q[k] !== 16'(22 + 10 * (k / 8) + (k % 8))) begin
        bad++; $display("FAIL midrst_val[%0d]: got %0d expected %0d", k, got_q[k], 22 + 10 * (k / 8) + (k % 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_random(1'b0, 1'b0);
    test_random(1'b1, 1'b1);
    test_backpressure();
    test_single_peak();
    test_degenerate();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
